nl_act_scheduler: RTL

- Sequences the nonlinear activation unit of the hwpe-mac-engine (ReLU / sigmoid / tanh).
- Accepts activation jobs from the engine controller into a small job FIFO.
- When a job needs it, streams the piecewise-linear coefficient table from a config memory into the activation unit's LUT write port.
- Drives the unit's enable and configuration, detects completion, and reports done/error per job.

---
 rtl/nl_act_scheduler_pkg.sv | 43 ++++
 rtl/nl_act_scheduler_job_fifo.sv | 64 ++++++
 rtl/nl_act_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nl_act_scheduler_pkg.sv
// Shared widths, function codes, job record and FSM encoding for the
// nonlinear activation scheduler.
package nl_act_scheduler_pkg;

  localparam int LUT_ADDR                           = 6;
  localparam int LUT_DATA_WIDTH                     = 16;
  localparam int NUMBER_OF_NONLINEAR_FUNCTIONS_BITS = 3;
  localparam int NL_FUNC_BITS                       = NUMBER_OF_NONLINEAR_FUNCTIONS_BITS;
  localparam int NL_LUT_WORDS                       = 58;
  localparam int JOB_FIFO_DEPTH                     = 4;

  localparam logic [NL_FUNC_BITS-1:0] NL_RELU    = 3'd0;
  localparam logic [NL_FUNC_BITS-1:0] NL_SIGMOID = 3'd3;
  localparam logic [NL_FUNC_BITS-1:0] NL_TANH    = 3'd4;

  typedef struct packed {
    logic [NL_FUNC_BITS-1:0] func;
    logic [31:0]             cycles;
    logic [7:0]              shift;
    logic                    lut_reload;
  } nl_job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CHECK,
    ST_LUT_LOAD,
    ST_LUT_DRAIN,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } nl_state_e;

  function automatic logic nl_func_supported(input logic [NL_FUNC_BITS-1:0] f);
    return (f == NL_RELU) || (f == NL_SIGMOID) || (f == NL_TANH);
  endfunction

  // Only the piecewise-linear functions read the coefficient table.
  function automatic logic nl_func_needs_lut(input logic [NL_FUNC_BITS-1:0] f);
    return (f == NL_SIGMOID) || (f == NL_TANH);
  endfunction

endpackage

// File: rtl/nl_act_scheduler_job_fifo.sv
// Synchronous FIFO of activation jobs; occupancy is registered so full/empty
// carry no combinational path from the push side.
module nl_job_fifo
  import nl_act_scheduler_pkg::*;
#(
  parameter int DEPTH = JOB_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  nl_job_t push_data,
  input  logic    pop,
  output nl_job_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  nl_job_t       mem_q [DEPTH];
  nl_job_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nl_act_scheduler.sv
// Job sequencer for the nonlinear activation unit: queues jobs, reloads the
// coefficient LUT when needed, runs the unit and reports done/error per job.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | nothing to do, waiting for a queued job
// ST_POP       | latch FIFO head into the config registers
// ST_CHECK     | decide between error, LUT reload or direct run
// ST_LUT_LOAD  | issue config-memory reads k = 0..LUT_WORDS-1
// ST_LUT_DRAIN | last LUT write lands, table marked valid
// ST_RUN       | unit enabled, waiting for finished_activation
// ST_DONE      | job_done pulse
// ST_ERR       | job_error pulse for an unsupported function code
module nl_act_scheduler
  import nl_act_scheduler_pkg::*;
#(
  parameter int LUT_WORDS  = NL_LUT_WORDS,
  parameter int FIFO_DEPTH = JOB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [NL_FUNC_BITS-1:0]   job_type,
  input  logic [31:0]               job_cycles,
  input  logic [7:0]                job_shift,
  input  logic                      job_lut_reload,
  output logic                      lut_src_rd_en,
  output logic [LUT_ADDR-1:0]       lut_src_rd_addr,
  input  logic [LUT_DATA_WIDTH-1:0] lut_src_rd_data,
  output logic                      wr_en_ext_lut,
  output logic [LUT_ADDR-1:0]       wr_addr_ext_lut,
  output logic [LUT_DATA_WIDTH-1:0] wr_data_ext_lut,
  output logic                      enable_nonlinear_block,
  output logic [NL_FUNC_BITS-1:0]   type_nonlinear_function,
  output logic [31:0]               NUMBER_OF_ACTIVATION_CYCLES,
  output logic [7:0]                SHIFT_FIXED_POINT,
  input  logic                      finished_activation,
  output logic                      busy,
  output logic                      job_done,
  output logic                      job_error
);

  localparam logic [LUT_ADDR-1:0] LAST_ADDR = LUT_ADDR'(LUT_WORDS - 1);

  nl_state_e           state_q, state_d;
  nl_job_t             cfg_q, cfg_d;
  logic                lut_valid_q, lut_valid_d;
  logic                rd_en_q, rd_en_d;
  logic [LUT_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [LUT_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic                enable_q, enable_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                run_first_q, run_first_d;
  logic                rst_done_q;

  nl_job_t fifo_push_data;
  nl_job_t fifo_head;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Holding ready low until the first edge after reset keeps every output at 0 in reset.
  assign job_ready = rst_done_q && !fifo_full;
  assign fifo_push = job_valid && job_ready;
  assign fifo_push_data = '{func: job_type, cycles: job_cycles,
                            shift: job_shift, lut_reload: job_lut_reload};

  nl_job_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_job_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    lut_valid_d = lut_valid_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    wr_en_d     = rd_en_q;
    wr_addr_d   = rd_addr_q;
    enable_d    = enable_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    run_first_d = 1'b0;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        fifo_pop = 1'b1;
        cfg_d    = fifo_head;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        if (!nl_func_supported(cfg_q.func)) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else if (nl_func_needs_lut(cfg_q.func) && (cfg_q.lut_reload || !lut_valid_q)) begin
          state_d   = ST_LUT_LOAD;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end else begin
          state_d     = ST_RUN;
          enable_d    = 1'b1;
          run_first_d = 1'b1;
        end
      end
      ST_LUT_LOAD: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_LUT_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_LUT_DRAIN: begin
        lut_valid_d = 1'b1;
        state_d     = ST_RUN;
        enable_d    = 1'b1;
        run_first_d = 1'b1;
      end
      ST_RUN: begin
        // finished_activation may still be high from the previous job on the first cycle.
        if (!run_first_q && finished_activation) begin
          state_d  = ST_DONE;
          enable_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = fifo_empty ? ST_IDLE : ST_POP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      lut_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      enable_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      run_first_q <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      lut_valid_q <= lut_valid_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      enable_q    <= enable_d;
      done_q      <= done_d;
      error_q     <= error_d;
      run_first_q <= run_first_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign lut_src_rd_en               = rd_en_q;
  assign lut_src_rd_addr             = rd_addr_q;
  assign wr_en_ext_lut               = wr_en_q;
  assign wr_addr_ext_lut             = wr_addr_q;
  // Read data arrives one cycle after the read, i.e. in the write cycle itself.
  assign wr_data_ext_lut             = wr_en_q ? lut_src_rd_data : '0;
  assign enable_nonlinear_block      = enable_q;
  assign type_nonlinear_function     = cfg_q.func;
  assign NUMBER_OF_ACTIVATION_CYCLES = cfg_q.cycles;
  assign SHIFT_FIXED_POINT           = cfg_q.shift;
  assign busy                        = (state_q != ST_IDLE) || !fifo_empty;
  assign job_done                    = done_q;
  assign job_error                   = error_q;

endmodule
